// File: rtl/rgb_pwm_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rgb_pwm_ctrl
//   Bus-mapped controller for the three PWM inputs of the SB_RGBA_DRV LED
//   driver. Each colour gets an 8-bit PWM. An optional "breathing" sequencer
//   ramps a brightness level up and down, and that level scales all three
//   duties.
//
// Ports
//   clk          system clock
//   resetn       synchronous, active-low reset
//   iomem_valid  bus request
//   iomem_ready  bus acknowledge, one-cycle pulse
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address; [31:24] block select, [3:2] register select
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
//   pwm_r/g/b    registered PWM outputs
//
// Register map (addr[3:2])
//   0 CTRL      [0] EN, [1] BREATHE
//   1 DUTY      [7:0] R, [15:8] G, [23:16] B
//   2 PRESCALE  [15:0] clk cycles per PWM tick minus 1
//   3 STATUS    RO: [7:0] level, [9:8] state (0 OFF, 1 STEADY, 2 UP, 3 DOWN)
// -----------------------------------------------------------------------------
module rgb_pwm_ctrl #(
  parameter logic [7:0]  ADDR_PREFIX  = 8'h04,
  parameter logic [15:0] PRESCALE_RST = 16'd46
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_STEADY = 2'd1,
    ST_UP     = 2'd2,
    ST_DOWN   = 2'd3
  } state_e;

  // Architectural registers
  logic [1:0]  ctrl_q, ctrl_d;
  logic [23:0] duty_q, duty_d;
  logic [15:0] prescale_q, prescale_d;

  // Bus response
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;

  // PWM timing and sequencer
  logic [15:0]     pre_cnt_q, pre_cnt_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [7:0]      level_q, level_d;
  state_e          state_q, state_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [2:0]      pwm_q, pwm_d;

  logic        access;
  logic        wr;
  logic [1:0]  sel;
  logic [31:0] reg_val;
  logic [31:0] wmask;
  logic [31:0] wr_val;
  logic        en;
  logic        breathe;
  logic        running;
  logic        tick;
  logic        period_end;
  logic        load_shadow;
  logic        prescale_wr;
  logic [2:0][7:0] eff;

  // Address bits below the block select (other than [3:2]) alias freely.
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], wr_val[31:24]};

  // Only a fresh request starts an access; the cycle ready is high is skipped
  // so a held valid does not produce a second acknowledge.
  assign access = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_PREFIX);
  assign wr     = access && (iomem_wstrb != 4'd0);
  assign sel    = iomem_addr[3:2];

  always_comb begin
    case (sel)
      2'd0:    reg_val = {30'd0, ctrl_q};
      2'd1:    reg_val = {8'd0, duty_q};
      2'd2:    reg_val = {16'd0, prescale_q};
      default: reg_val = {22'd0, state_q, level_q};
    endcase
  end

  assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  // Byte-merge the write data into the currently addressed register.
  assign wr_val = (reg_val & ~wmask) | (iomem_wdata & wmask);

  always_comb begin
    ctrl_d     = ctrl_q;
    duty_d     = duty_q;
    prescale_d = prescale_q;
    if (wr) begin
      case (sel)
        2'd0:    ctrl_d     = wr_val[1:0];
        2'd1:    duty_d     = wr_val[23:0];
        2'd2:    prescale_d = wr_val[15:0];
        default: ;
      endcase
    end
  end

  // Read data reflects the register before any same-cycle write.
  assign rdata_d     = access ? reg_val : 32'd0;
  assign prescale_wr = wr && (sel == 2'd2);

  assign en         = ctrl_q[0];
  assign breathe    = ctrl_q[1];
  // Counters stay at zero in OFF, including the cycle that leaves OFF, so the
  // first period starts cleanly with freshly loaded shadows.
  assign running    = en && (state_q != ST_OFF);
  assign tick       = (pre_cnt_q == prescale_q);
  assign period_end = running && tick && (pwm_cnt_q == 8'hFF);

  always_comb begin
    if (!running) begin
      pre_cnt_d = 16'd0;
      pwm_cnt_d = 8'd0;
    end else begin
      pre_cnt_d = (tick || prescale_wr) ? 16'd0 : pre_cnt_q + 16'd1;
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end
  end

  // Sequencer next state; CTRL changes take priority over the ramp.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    load_shadow = period_end;
    if (!en) begin
      state_d = ST_OFF;
      level_d = 8'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = breathe ? ST_UP : ST_STEADY;
          level_d     = breathe ? 8'd0 : 8'hFF;
          load_shadow = 1'b1;
        end
        ST_STEADY: begin
          if (breathe) state_d = ST_DOWN;
        end
        ST_UP: begin
          if (!breathe) begin
            state_d = ST_STEADY;
            level_d = 8'hFF;
          end else if (period_end) begin
            level_d = level_q + 8'd1;
            if (level_q == 8'd254) state_d = ST_DOWN;
          end
        end
        default: begin
          if (!breathe) begin
            state_d = ST_STEADY;
            level_d = 8'hFF;
          end else if (period_end) begin
            level_d = level_q - 8'd1;
            if (level_q == 8'd1) state_d = ST_UP;
          end
        end
      endcase
    end
  end

  // Effective duty uses the level that will apply during the next period, so
  // the period that starts at a ramp step already shows the new brightness.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_colour
      logic [7:0]  duty_x;
      logic [15:0] prod;
      assign duty_x = duty_q[gi*8 +: 8];
      assign prod   = {8'd0, duty_x} * {8'd0, level_d};
      always_comb begin
        case (state_d)
          ST_STEADY:     eff[gi] = duty_x;
          ST_UP, ST_DOWN: eff[gi] = prod[15:8];
          default:       eff[gi] = 8'd0;
        endcase
      end
      assign shadow_d[gi] = load_shadow ? eff[gi] : shadow_q[gi];
      assign pwm_d[gi]    = running && (pwm_cnt_q < shadow_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q     <= 2'd0;
      duty_q     <= 24'd0;
      prescale_q <= PRESCALE_RST;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      pre_cnt_q  <= 16'd0;
      pwm_cnt_q  <= 8'd0;
      level_q    <= 8'd0;
      state_q    <= ST_OFF;
      shadow_q   <= '0;
      pwm_q      <= 3'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      duty_q     <= duty_d;
      prescale_q <= prescale_d;
      ready_q    <= access;
      rdata_q    <= rdata_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pwm_q      <= pwm_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pwm_r       = pwm_q[0];
  assign pwm_g       = pwm_q[1];
  assign pwm_b       = pwm_q[2];

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
`timescale 1ns/1ps
// Directed bench for rgb_pwm_ctrl: bus register access, steady PWM, duty
// shadowing, breathing ramp and reset behaviour.
module tb_rgb_pwm_ctrl;

  localparam logic [31:0] A_CTRL = 32'h0400_0000;
  localparam logic [31:0] A_DUTY = 32'h0400_0004;
  localparam logic [31:0] A_PRE  = 32'h0400_0008;
  localparam logic [31:0] A_STAT = 32'h0400_000C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        pwm_r, pwm_g, pwm_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  rgb_pwm_ctrl dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; expected read data goes through the scoreboard.
  task automatic bus(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    int lat;
    bit got;
    logic [31:0] e;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd; iomem_valid = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      got = iomem_ready;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    e = exp_q.pop_front();
    $display("[TB] %s addr=%h wstrb=%b wdata=%h rdata=%h lat=%0d", tag, addr, strb, wd, iomem_rdata, lat);
    check({tag, "_ready"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, "_lat"}, lat, 32'd1);
      check(tag, iomem_rdata, e);
    end
  endtask

  task automatic nomatch(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd; iomem_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1'b1;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    $display("[TB] %s addr=%h wstrb=%b ready_seen=%0d", tag, addr, strb, seen);
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic count_hi(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r += int'(pwm_r); g += int'(pwm_g); b += int'(pwm_b);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits for a 0->1 edge of pwm_r, counting high samples seen before it.
  task automatic wait_rise(input int bound, output int highs, output bit ok);
    logic prev;
    int n;
    prev = pwm_r; n = 0; ok = 1'b0; highs = 0;
    while (!ok && n < bound) begin
      @(posedge clk); #1;
      n++;
      if (!prev && pwm_r) ok = 1'b1;
      else if (pwm_r) highs++;
      prev = pwm_r;
    end
  endtask

  initial begin
    int r, g, b, hb, t0;
    bit ok;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    resetn = 1'b1;
    bus("rd_pre_rst", A_PRE, 4'h0, 32'd0, 32'd46);
    bus("rd_stat_rst", A_STAT, 4'h0, 32'd0, 32'd0);
    bus("rd_ctrl_rst", A_CTRL, 4'h0, 32'd0, 32'd0);
    bus("rd_duty_rst", A_DUTY, 4'h0, 32'd0, 32'd0);

    // Register access, strobes, aliasing, non-matching prefix
    bus("wr_duty", A_DUTY, 4'hF, 32'h0012_3456, 32'd0);
    @(posedge clk); #1;
    check("ready_once", {31'd0, iomem_ready}, 32'd0);
    bus("rd_duty", A_DUTY, 4'h0, 32'd0, 32'h0012_3456);
    bus("rd_alias", 32'h04FF_FF04, 4'h0, 32'd0, 32'h0012_3456);
    bus("wr_byte1", A_DUTY, 4'b0010, 32'hAABB_CCDD, 32'h0012_3456);
    bus("rd_byte1", A_DUTY, 4'h0, 32'd0, 32'h0012_CC56);
    bus("wr_duty_all", A_DUTY, 4'hF, 32'hFFFF_FFFF, 32'h0012_CC56);
    bus("rd_duty_mask", A_DUTY, 4'h0, 32'd0, 32'h00FF_FFFF);
    bus("wr_stat", A_STAT, 4'hF, 32'hFFFF_FFFF, 32'd0);
    bus("rd_stat_ro", A_STAT, 4'h0, 32'd0, 32'd0);
    nomatch("nomatch_wr", 32'h0500_0004, 4'hF, 32'd0);
    bus("rd_duty_kept", A_DUTY, 4'h0, 32'd0, 32'h00FF_FFFF);

    // Steady PWM
    bus("wr_pre0", A_PRE, 4'hF, 32'hABCD_0000, 32'd46);
    bus("rd_pre0", A_PRE, 4'h0, 32'd0, 32'd0);
    bus("wr_duty_ff80", A_DUTY, 4'hF, 32'h0000_FF80, 32'h00FF_FFFF);
    bus("wr_ctrl_en", A_CTRL, 4'hF, 32'd1, 32'd0);
    repeat (300) @(posedge clk);
    count_hi(256, r, g, b);
    check("steady_r", r, 32'd128);
    check("steady_g", g, 32'd255);
    check("steady_b", b, 32'd0);
    bus("rd_stat_steady", A_STAT, 4'h0, 32'd0, 32'h0000_01FF);

    // Mid-period duty write is deferred to the next period
    bus("wr_duty_40", A_DUTY, 4'hF, 32'h0000_0040, 32'h0000_FF80);
    wait_rise(600, hb, ok);
    check("rise1_seen", {31'd0, ok}, 32'd1);
    count_hi(99, r, g, b);
    check("r_head_64", r + 1, 32'd64);
    bus("wr_duty_c0", A_DUTY, 4'b0001, 32'h0000_00C0, 32'h0000_0040);
    wait_rise(300, hb, ok);
    check("rise2_seen", {31'd0, ok}, 32'd1);
    check("r_tail_low", hb, 32'd0);
    count_hi(255, r, g, b);
    check("r_next_192", r + 1, 32'd192);
    check("g_next_0", g, 32'd0);
    bus("wr_ctrl_br", A_CTRL, 4'hF, 32'd3, 32'd1);
    bus("rd_stat_down", A_STAT, 4'h0, 32'd0, 32'h0000_03FF);
    bus("wr_ctrl_st", A_CTRL, 4'hF, 32'd1, 32'd3);
    bus("rd_stat_st", A_STAT, 4'h0, 32'd0, 32'h0000_01FF);
    wait_rise(600, hb, ok);
    check("rise3_seen", {31'd0, ok}, 32'd1);
    bus("wr_ctrl_off", A_CTRL, 4'hF, 32'd0, 32'd1);
    check("r_high_at_off", {31'd0, pwm_r}, 32'd1);
    @(posedge clk); #1;
    check("r_low_after_off", {31'd0, pwm_r}, 32'd0);
    bus("rd_stat_off", A_STAT, 4'h0, 32'd0, 32'd0);
    count_hi(300, r, g, b);
    check("off_r", r, 32'd0);

    // Breathing ramp
    bus("wr_duty_ff", A_DUTY, 4'hF, 32'h0000_00FF, 32'h0000_00C0);
    bus("wr_ctrl_breathe", A_CTRL, 4'hF, 32'd3, 32'd0);
    t0 = cyc;
    wait_until(t0 + 128);
    bus("rd_lvl0", A_STAT, 4'h0, 32'd0, 32'h0000_0200);
    wait_until(t0 + 1 + 256 * 2);
    count_hi(256, r, g, b);
    check("breath_p2_r", r, 32'd1);
    wait_until(t0 + 128 + 256 * 3);
    bus("rd_lvl3", A_STAT, 4'h0, 32'd0, 32'h0000_0203);
    wait_until(t0 + 1 + 256 * 100);
    count_hi(256, r, g, b);
    check("breath_p100_r", r, 32'd99);
    check("breath_p100_g", g, 32'd0);
    wait_until(t0 + 128 + 256 * 101);
    bus("rd_lvl101", A_STAT, 4'h0, 32'd0, 32'h0000_0265);
    wait_until(t0 + 128 + 256 * 254);
    bus("rd_lvl254_up", A_STAT, 4'h0, 32'd0, 32'h0000_02FE);
    wait_until(t0 + 128 + 256 * 255);
    bus("rd_lvl255_down", A_STAT, 4'h0, 32'd0, 32'h0000_03FF);
    wait_until(t0 + 1 + 256 * 256);
    count_hi(256, r, g, b);
    check("breath_p256_r", r, 32'd253);
    check("breath_p256_b", b, 32'd0);

    // Reset while breathing
    wait_until(t0 + 2 + 256 * 257 + 10);
    check("r_high_pre_rst", {31'd0, pwm_r}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst2_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
    check("rst2_ready", {31'd0, iomem_ready}, 32'd0);
    resetn = 1'b1;
    bus("rd_ctrl_rst2", A_CTRL, 4'h0, 32'd0, 32'd0);
    bus("rd_stat_rst2", A_STAT, 4'h0, 32'd0, 32'd0);
    bus("rd_pre_rst2", A_PRE, 4'h0, 32'd0, 32'd46);
    bus("rd_duty_rst2", A_DUTY, 4'h0, 32'd0, 32'd0);
    count_hi(300, r, g, b);
    check("rst2_r_idle", r, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
